// File: rtl/mem_responder_pkg.sv
// Shared constants for the CPU memory path: responder state encodings,
// default wait count, data width and the CPU address-source codes.
package mem_responder_pkg;

    localparam int MR_DATA_W       = 16;
    localparam int MR_DEFAULT_WAIT = 1;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

    // CPU address mux select codes; the responder sits behind this mux.
    typedef enum logic [1:0] {
        READ_FROM_PC  = 2'd0,
        READ_FROM_ALU = 2'd1,
        READ_FROM_IMM = 2'd2
    } addr_src_t;

endpackage

// File: rtl/mem_responder_word_ram.sv
// Single-port synchronous RAM with registered read data; no reset so the
// array maps onto block memory.
module word_ram #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one request at a time, waits a
// fixed number of cycles, then answers with a one-cycle ack from word_ram.
//
// state   | meaning
// --------+-------------------------------------------------------------
// MR_IDLE | waiting for req; accepting edge latches the request
// MR_WAIT | counting down wait states, inputs ignored
// MR_RESP | ack high for one cycle, write committed at its closing edge
import mem_responder_pkg::*;

module mem_responder #(
    parameter int DATA_W      = MR_DATA_W,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = MR_DEFAULT_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    mr_state_t state, state_nxt;

    logic [3:0]            cnt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     rdata_hold;
    logic [DATA_W-1:0]     rdata_now;
    logic                  in_range;
    logic                  resp_read;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MR_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES == 0) ? MR_RESP : MR_WAIT;
                end
            end
            MR_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = MR_RESP;
                end
            end
            MR_RESP: state_nxt = MR_IDLE;
            default: state_nxt = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (state == MR_IDLE && req) begin
            cnt     <= WAIT_LOAD;
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end else if (state == MR_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign in_range  = (r_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign resp_read = (state == MR_RESP) && !r_we;

    // The RAM read must be launched one cycle ahead of RESP. With no wait
    // states that cycle is the accepting one, so IDLE reads the live address.
    assign ram_addr = (state == MR_IDLE) ? addr[DEPTH_LOG2-1:0] : r_addr[DEPTH_LOG2-1:0];
    assign ram_we   = (state == MR_RESP) && r_we && in_range;

    word_ram #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_word_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(r_wdata),
        .rdata(ram_rdata)
    );

    assign rdata_now = in_range ? ram_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold <= '0;
        end else if (resp_read) begin
            rdata_hold <= rdata_now;
        end
    end

    assign busy  = (state != MR_IDLE);
    assign ack   = (state == MR_RESP);
    assign err   = ack && !in_range;
    assign rdata = resp_read ? rdata_now : rdata_hold;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances with wait counts 1, 0, 3
// and 15 share clock and reset; each scenario drives one of them.
`timescale 1ns/1ps

module tb_mem_responder;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req_v   = '0;
    logic [3:0]        we_v    = '0;
    logic [3:0][15:0]  addr_v  = '0;
    logic [3:0][15:0]  wdata_v = '0;
    logic [3:0]        busy_v;
    logic [3:0]        ack_v;
    logic [3:0][15:0]  rdata_v;
    logic [3:0]        err_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder #(
            .DATA_W     (16),
            .ADDR_W     (16),
            .DEPTH_LOG2 (8),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : (g == 2 ? 3 : 15)))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .req  (req_v[g]),
            .we   (we_v[g]),
            .addr (addr_v[g]),
            .wdata(wdata_v[g]),
            .busy (busy_v[g]),
            .ack  (ack_v[g]),
            .rdata(rdata_v[g]),
            .err  (err_v[g])
        );
    end

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    // One full request on instance i; optionally disturbs the inputs while
    // the request is in flight to show the latched copy is served.
    task automatic transact(input int i, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic exp_err,
                            input logic [15:0] exp_rd, input logic scramble,
                            input string name);
        int cycles;
        @(negedge clk);
        req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = a; wdata_v[i] = d;
        @(negedge clk);
        req_v[i] = 1'b0;
        cycles = 1;
        while (ack_v[i] !== 1'b1 && cycles < 40) begin
            checks++;
            if (busy_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_wait: got %b want 1 (cycle %0d)", name, busy_v[i], cycles);
            end
            if (scramble) begin
                addr_v[i] = 16'h0030; we_v[i] = ~w; wdata_v[i] = 16'hDEAD;
            end
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != wait_of(i) + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cycles, wait_of(i) + 1);
        end
        checks++;
        if (busy_v[i] !== 1'b1 || err_v[i] !== exp_err) begin
            errors++;
            $display("FAIL %s busy/err at ack: got %b/%b want 1/%b", name, busy_v[i], err_v[i], exp_err);
        end
        checks++;
        if (rdata_v[i] !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, rdata_v[i], exp_rd);
        end
        @(negedge clk);
        checks++;
        if (ack_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || err_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s after ack: ack/busy/err got %b/%b/%b want 0/0/0", name, ack_v[i], busy_v[i], err_v[i]);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy_v !== 4'h0 || ack_v !== 4'h0 || err_v !== 4'h0 || rdata_v !== '0) begin
            errors++;
            $display("FAIL reset_asserted: busy=%h ack=%h err=%h want 0", busy_v, ack_v, err_v);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (busy_v !== 4'h0 || ack_v !== 4'h0 || err_v !== 4'h0 || rdata_v !== '0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: busy=%h ack=%h err=%h want 0", k, busy_v, ack_v, err_v);
            end
        end
    endtask

    task automatic test_write_read();
        transact(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, "wr_0010");
        transact(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0, "rd_0010");
        transact(0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'hBEEF, 1'b0, "wr_0000_hold");
    endtask

    task automatic test_out_of_range();
        transact(0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b0, "rd_oor");
        transact(0, 1'b1, 16'h0100, 16'hFFFF, 1'b1, 16'h0000, 1'b0, "wr_oor");
        transact(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5, 1'b0, "rd_0000_after_oor");
    endtask

    task automatic test_back_to_back();
        int acks;
        transact(1, 1'b1, 16'h0001, 16'h0777, 1'b0, 16'h0000, 1'b0, "wr_0001");
        acks = 0;
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 16'h0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (ack_v[1] !== 1'(k % 2)) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: got %b want %b", k, ack_v[1], 1'(k % 2));
            end
            if (ack_v[1] === 1'b1) begin
                acks++;
                checks++;
                if (rdata_v[1] !== 16'h0777) begin
                    errors++;
                    $display("FAIL b2b_rdata[%0d]: got %h want 0777", k, rdata_v[1]);
                end
            end
            addr_v[1] = (k % 2 == 1) ? 16'h00FF : 16'h0001;
        end
        req_v[1] = 1'b0;
        checks++;
        if (acks != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d acks want 5", acks);
        end
        @(negedge clk);
        checks++;
        if (ack_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: ack/busy got %b/%b want 0/0", ack_v[1], busy_v[1]);
        end
    endtask

    task automatic test_reset_mid_op();
        transact(2, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b0, "wr_0020");
        transact(2, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234, 1'b1, "rd_0020_scrambled");
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 16'h0020; wdata_v[2] = 16'h5678;
        @(negedge clk);
        req_v[2] = 1'b0;
        checks++;
        if (busy_v[2] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: got %b want 1", busy_v[2]);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy_v[2] !== 1'b0 || ack_v[2] !== 1'b0 || err_v[2] !== 1'b0 || rdata_v[2] !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_outputs: busy/ack/err=%b/%b/%b rdata=%h want 0", busy_v[2], ack_v[2], err_v[2], rdata_v[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        transact(2, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234, 1'b0, "rd_0020_after_rst");
    endtask

    task automatic test_long_wait();
        transact(3, 1'b1, 16'h0005, 16'h5A5A, 1'b0, 16'h0000, 1'b0, "wr_0005_w15");
        transact(3, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h5A5A, 1'b0, "rd_0005_w15");
    endtask

    initial begin
        #1;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        test_long_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
